// File: rtl/fifo_sync_param.sv
// Single-clock FIFO of arbitrary depth with a registered or first-word-fall-through read port,
// occupancy count, almost-full/almost-empty flags, overflow/underflow pulses and a synchronous flush.
module fifo_sync_param #(
    parameter int DATAW     = 8,
    parameter int DEPTH     = 4,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic [DATAW-1:0] i_wr_data,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic             o_wr_full,
    output logic             o_rd_empty,
    output logic [DATAW-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic [CNTW-1:0]  o_count,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int PTRW = $clog2(DEPTH);
    localparam logic [PTRW-1:0] LAST_PTR = PTRW'(DEPTH - 1);
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] AF_C     = CNTW'(AF_THRESH);
    localparam logic [CNTW-1:0] AE_C     = CNTW'(AE_THRESH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [CNTW-1:0]  count;
    logic             wr_acc;
    logic             rd_acc;

    assign o_count        = count;
    assign o_wr_full      = (count == DEPTH_C);
    assign o_rd_empty     = (count == '0);
    assign o_almost_full  = (count >= AF_C);
    assign o_almost_empty = (count <= AE_C);

    // Accept decisions use only pre-edge flags: no write-through-full or read-through-empty bypass.
    assign wr_acc = i_wr_en && !o_wr_full  && !i_flush;
    assign rd_acc = i_rd_en && !o_rd_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= i_wr_en && o_wr_full;
            o_underflow <= i_rd_en && o_rd_empty;
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    o_rd_data  <= '0;
                    o_rd_valid <= 1'b0;
                end else begin
                    o_rd_valid <= rd_acc;
                    if (rd_acc) begin
                        o_rd_data <= mem[rd_ptr];
                    end
                end
            end
        end else begin : g_fwft
            assign o_rd_data  = mem[rd_ptr];
            assign o_rd_valid = !o_rd_empty;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives three FIFO configurations (default, DEPTH=5, FWFT) with identical stimulus and compares
// every output each cycle against an ordered-list model of FIFO behaviour.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;

    logic       full_w  [3];
    logic       empty_w [3];
    logic [7:0] data_w  [3];
    logic       valid_w [3];
    logic [2:0] cnt_w   [3];
    logic       af_w    [3];
    logic       ae_w    [3];
    logic       ovf_w   [3];
    logic       udf_w   [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Model configuration and state per instance
    int         m_depth [3] = '{4, 5, 4};
    int         m_fwft  [3] = '{0, 0, 1};
    int         m_af    [3] = '{3, 4, 2};
    int         m_ae    [3] = '{1, 1, 2};
    logic [7:0] m_list  [3][8];
    int         m_cnt   [3];
    logic [7:0] m_data  [3];
    logic       m_valid [3];
    logic       m_ovf   [3];
    logic       m_udf   [3];

    always #5 clk = ~clk;

    fifo_sync_param u0 (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_wr_data(wr_data), .i_wr_en(wr_en),
        .i_rd_en(rd_en), .o_wr_full(full_w[0]), .o_rd_empty(empty_w[0]), .o_rd_data(data_w[0]),
        .o_rd_valid(valid_w[0]), .o_count(cnt_w[0]), .o_almost_full(af_w[0]),
        .o_almost_empty(ae_w[0]), .o_overflow(ovf_w[0]), .o_underflow(udf_w[0])
    );

    fifo_sync_param #(.DEPTH(5)) u1 (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_wr_data(wr_data), .i_wr_en(wr_en),
        .i_rd_en(rd_en), .o_wr_full(full_w[1]), .o_rd_empty(empty_w[1]), .o_rd_data(data_w[1]),
        .o_rd_valid(valid_w[1]), .o_count(cnt_w[1]), .o_almost_full(af_w[1]),
        .o_almost_empty(ae_w[1]), .o_overflow(ovf_w[1]), .o_underflow(udf_w[1])
    );

    fifo_sync_param #(.FWFT(1), .AF_THRESH(2), .AE_THRESH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_wr_data(wr_data), .i_wr_en(wr_en),
        .i_rd_en(rd_en), .o_wr_full(full_w[2]), .o_rd_empty(empty_w[2]), .o_rd_data(data_w[2]),
        .o_rd_valid(valid_w[2]), .o_count(cnt_w[2]), .o_almost_full(af_w[2]),
        .o_almost_empty(ae_w[2]), .o_overflow(ovf_w[2]), .o_underflow(udf_w[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic full;
        logic empty;
        logic [7:0] head;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_cnt[k] = 0; m_data[k] = '0; m_valid[k] = 1'b0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
            end else if (flush) begin
                m_cnt[k] = 0; m_valid[k] = 1'b0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
            end else begin
                full  = (m_cnt[k] == m_depth[k]);
                empty = (m_cnt[k] == 0);
                m_ovf[k] = wr_en && full;
                m_udf[k] = rd_en && empty;
                m_valid[k] = 1'b0;
                if (rd_en && !empty) begin
                    head = m_list[k][0];
                    for (int i = 0; i < 7; i++) m_list[k][i] = m_list[k][i+1];
                    m_cnt[k]--;
                    m_valid[k] = 1'b1;
                    m_data[k]  = head;
                end
                if (wr_en && !full) begin
                    m_list[k][m_cnt[k]] = wr_data;
                    m_cnt[k]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d.count", k), 32'(cnt_w[k]), 32'(m_cnt[k]));
            check($sformatf("u%0d.full", k), 32'(full_w[k]), 32'(m_cnt[k] == m_depth[k]));
            check($sformatf("u%0d.empty", k), 32'(empty_w[k]), 32'(m_cnt[k] == 0));
            check($sformatf("u%0d.afull", k), 32'(af_w[k]), 32'(m_cnt[k] >= m_af[k]));
            check($sformatf("u%0d.aempty", k), 32'(ae_w[k]), 32'(m_cnt[k] <= m_ae[k]));
            check($sformatf("u%0d.overflow", k), 32'(ovf_w[k]), 32'(m_ovf[k]));
            check($sformatf("u%0d.underflow", k), 32'(udf_w[k]), 32'(m_udf[k]));
            if (m_fwft[k] == 0) begin
                check($sformatf("u%0d.rd_valid", k), 32'(valid_w[k]), 32'(m_valid[k]));
                check($sformatf("u%0d.rd_data", k), 32'(data_w[k]), 32'(m_data[k]));
            end else begin
                check($sformatf("u%0d.rd_valid", k), 32'(valid_w[k]), 32'(m_cnt[k] != 0));
                if (m_cnt[k] != 0)
                    check($sformatf("u%0d.rd_data", k), 32'(data_w[k]), 32'(m_list[k][0]));
            end
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic wr, input logic rd,
                        input logic [7:0] d);
        rst_n = rst; flush = fl; wr_en = wr; rd_en = rd; wr_data = d;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        // Fill, overfill, then drain past empty
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h05);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // FWFT write into empty, then pop
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // Hold count at 2 with simultaneous read/write through several pointer wraps
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h10);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'(8'h20 + i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        // Flush with concurrent write and read requests
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h3F);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h40);
        // Reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'(8'h50 + i));
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h5F);
        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) != 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), 8'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Single-clock synchronous FIFO, the parametrised successor of the team's fixed 8-bit x 4-entry FIFO.
- Arbitrary depth, not restricted to a power of two.
- Selectable read mode: registered (standard) or first-word-fall-through (FWFT).
- Occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses and a synchronous flush.
- Used as the generic buffering element between producer/consumer stages in the same clock domain.

Parameters:
DATAW, 8, data word width in bits (>=1)
DEPTH, 4, number of storage entries (>=2, any integer)
FWFT, 0, read mode: 0 = registered read data one cycle after accepted read; 1 = head word visible whenever not empty
AF_THRESH, DEPTH-1, o_almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, o_almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
CNTW, $clog2(DEPTH+1), derived; width of o_count

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
i_flush  input  1  synchronous clear of contents; priority over i_wr_en/i_rd_en
i_wr_data  input  DATAW  write data
i_wr_en  input  1  write request
i_rd_en  input  1  read request (FWFT=1: pop/acknowledge of head word)
o_wr_full  output  1  count == DEPTH
o_rd_empty  output  1  count == 0
o_rd_data  output  DATAW  read data
o_rd_valid  output  1  o_rd_data holds a valid word
o_count  output  CNTW  current occupancy, 0..DEPTH
o_almost_full  output  1  count >= AF_THRESH
o_almost_empty  output  1  count <= AE_THRESH
o_overflow  output  1  one-cycle pulse: write request rejected
o_underflow  output  1  one-cycle pulse: read request rejected

Behaviour:
- Reset (rst_n==0 at a rising edge): wr_ptr=rd_ptr=0, count=0, o_rd_data=0, o_rd_valid=0, o_overflow=o_underflow=0. Result: o_rd_empty=1, o_wr_full=0, o_almost_empty=1, o_almost_full=0 (AF_THRESH>=1). Storage array is not cleared. Reset mid-operation discards all contents and drops any in-flight read.
- Write accepted iff i_wr_en && !o_wr_full && !i_flush.
  - Stores i_wr_data at wr_ptr.
  - wr_ptr wraps from DEPTH-1 to 0 (explicit compare, no power-of-two reliance).
- Read accepted iff i_rd_en && !o_rd_empty && !i_flush. rd_ptr wraps identically.
- Full and empty flags use pre-edge state only. No same-cycle bypass:
  - Full + simultaneous rd/wr: only the read is accepted; write is dropped and o_overflow pulses.
  - Empty + simultaneous rd/wr: only the write is accepted; o_underflow pulses.
- count update: +1 on write only, -1 on read only, unchanged on both or neither. Never exceeds DEPTH, never below 0. All flags are combinational from registered count.
- o_overflow = registered (i_wr_en && o_wr_full && !i_flush): high the cycle after the rejected request, for one cycle. o_underflow is the same with i_rd_en/o_rd_empty. Neither alters FIFO state.
- FWFT=0 (standard mode):
  - On an accepted read, o_rd_data <= mem[rd_ptr] and o_rd_valid <= 1. Latency is 1 cycle.
  - o_rd_valid <= 0 on any cycle without an accepted read.
  - o_rd_data holds its last value otherwise.
- FWFT=1:
  - o_rd_data = mem[rd_ptr], combinational from registered pointer. o_rd_valid = !o_rd_empty.
  - An accepted read advances to the next word on the following cycle.
  - A word written into an empty FIFO is visible the cycle after the write edge.
- i_flush: at the edge, pointers and count are cleared and o_rd_valid is cleared. o_rd_data is held in mode 0. Write/read in the same cycle are ignored and no error pulses are raised. rst_n has priority over i_flush.
- Expected size: ~150-250 lines RTL.

Test Plan:
- Defaults (DATAW=8, DEPTH=4, FWFT=0). Reset, then write 1,2,3,4 on consecutive cycles -> o_count steps 1..4; o_almost_full=1 at count 3; o_wr_full=1 after 4th write; o_rd_empty=0.
- Continue from full. Read 4 cycles -> o_rd_data=1,2,3,4 each one cycle after its read with o_rd_valid=1; o_rd_empty=1 and o_almost_empty=1 at end.
- Write while full (data 5) -> o_overflow pulses one cycle; count stays 4; later reads still return 1..4. Read while empty -> o_underflow pulses; o_rd_valid=0.
- Wrap/simultaneous, DEPTH=5 (non-power-of-two). Stream 20 words with rd/wr asserted together at count 2 -> count stays 2; output order exact; pointers wrap through 4->0 with no loss.
- FWFT=1. Write 0xA5 into empty FIFO -> next cycle o_rd_data=0xA5 and o_rd_valid=1 with no read. Pop -> o_rd_valid=0, o_rd_empty=1.
- Fill 3 words, then assert i_flush together with i_wr_en -> count=0, o_rd_empty=1, no overflow. Separately, rst_n low mid-stream -> all outputs return to reset values on the next edge.
